// File: rtl/axi_protocol_monitor.sv
// Passive AXI4 bus monitor. It checks channel stability, burst length, in-order IDs,
// outstanding overflow and VALID hangs, and records violations as sticky error flags.
module axi_protocol_monitor #(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic                    err_clear,
    output logic [11:0]             err_vec,
    output logic                    err_pulse,
    output logic [3:0]              first_err_code,
    output logic                    err_any
);

    localparam int PW   = $clog2(MAX_OUTSTANDING);
    localparam int CW   = PW + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int A_PL = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
    localparam int W_PL = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_PL = ID_WIDTH + 2;
    localparam int R_PL = ID_WIDTH + DATA_WIDTH + 3;
    localparam logic [CW-1:0] Q_FULL = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    function automatic logic [3:0] lowest_bit(input logic [11:0] v);
        lowest_bit = 4'd0;
        for (int i = 11; i >= 0; i--) if (v[i]) lowest_bit = 4'(i);
    endfunction

    // Channel order in every 5-bit vector: AW, W, AR, B, R.
    logic [4:0] vld, rdy, hs, stall_q;
    assign vld = {rvalid, bvalid, arvalid, wvalid, awvalid};
    assign rdy = {rready, bready, arready, wready, awready};
    assign hs  = vld & rdy;

    logic [A_PL-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
    logic [W_PL-1:0] w_pl, w_pl_q;
    logic [B_PL-1:0] b_pl, b_pl_q;
    logic [R_PL-1:0] r_pl, r_pl_q;
    assign aw_pl = {awid, awaddr, awlen, awsize, awburst};
    assign ar_pl = {arid, araddr, arlen, arsize, arburst};
    assign w_pl  = {wdata, wstrb, wlast};
    assign b_pl  = {bid, bresp};
    assign r_pl  = {rid, rdata, rresp, rlast};

    logic [ID_WIDTH-1:0]  awq_id [MAX_OUTSTANDING];
    logic [LEN_WIDTH-1:0] awq_len[MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0]  bq_id  [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0]  arq_id [MAX_OUTSTANDING];
    logic [LEN_WIDTH-1:0] arq_len[MAX_OUTSTANDING];
    logic [PW-1:0] awq_wr_q, awq_rd_q, bq_wr_q, bq_rd_q, arq_wr_q, arq_rd_q;
    logic [CW-1:0] awq_cnt_q, bq_cnt_q, arq_cnt_q;
    logic [LEN_WIDTH:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [TW-1:0] to_cnt_q[5], to_cnt_d[5];

    logic aw_empty, b_empty, ar_empty, aw_full, b_full, ar_full;
    logic w_last_exp, r_last_exp, w_done, r_done, b_pop;
    logic aw_push_ok, b_push_ok, ar_push_ok;
    assign aw_empty   = (awq_cnt_q == '0);
    assign b_empty    = (bq_cnt_q == '0);
    assign ar_empty   = (arq_cnt_q == '0);
    assign aw_full    = (awq_cnt_q == Q_FULL);
    assign b_full     = (bq_cnt_q == Q_FULL);
    assign ar_full    = (arq_cnt_q == Q_FULL);
    assign w_last_exp = (wcnt_q == {1'b0, awq_len[awq_rd_q]});
    assign r_last_exp = (rcnt_q == {1'b0, arq_len[arq_rd_q]});
    assign w_done     = hs[1] && !aw_empty && (wlast || w_last_exp);
    assign r_done     = hs[4] && !ar_empty && (rlast || r_last_exp);
    assign b_pop      = hs[3] && !b_empty;
    assign aw_push_ok = hs[0] && (!aw_full || w_done);
    assign b_push_ok  = w_done && (!b_full || b_pop);
    assign ar_push_ok = hs[2] && (!ar_full || r_done);

    logic [11:0] viol, err_vec_q, err_vec_d, err_base;
    logic        err_pulse_q, err_pulse_d;
    logic [3:0]  code_q, code_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        viol     = '0;
        viol[0]  = stall_q[0] && (!awvalid || aw_pl != aw_pl_q);
        viol[1]  = stall_q[1] && (!wvalid || w_pl != w_pl_q);
        viol[2]  = stall_q[2] && (!arvalid || ar_pl != ar_pl_q);
        viol[3]  = stall_q[3] && (!bvalid || b_pl != b_pl_q);
        viol[4]  = stall_q[4] && (!rvalid || r_pl != r_pl_q);
        viol[5]  = hs[1] && !aw_empty && (wlast != w_last_exp);
        viol[6]  = hs[4] && !ar_empty && (rlast != r_last_exp);
        viol[7]  = hs[1] && aw_empty;
        viol[8]  = hs[3] && (b_empty || bid != bq_id[bq_rd_q]);
        viol[9]  = hs[4] && (ar_empty || rid != arq_id[arq_rd_q]);
        viol[10] = (hs[0] && !aw_push_ok) || (w_done && !b_push_ok) || (hs[2] && !ar_push_ok);

        wcnt_d = wcnt_q;
        if (hs[1] && !aw_empty) wcnt_d = w_done ? '0 : wcnt_q + 1'b1;
        rcnt_d = rcnt_q;
        if (hs[4] && !ar_empty) rcnt_d = r_done ? '0 : rcnt_q + 1'b1;

        // Saturating stall counters; a hang is flagged only on the cycle the limit is reached.
        for (int i = 0; i < 5; i++) begin
            to_cnt_d[i] = '0;
            if (vld[i] && !rdy[i]) begin
                to_cnt_d[i] = (to_cnt_q[i] == TO_MAX) ? to_cnt_q[i] : to_cnt_q[i] + 1'b1;
                if (to_cnt_q[i] != TO_MAX && to_cnt_d[i] == TO_MAX) viol[11] = 1'b1;
            end
        end

        err_base    = err_clear ? '0 : err_vec_q;
        err_vec_d   = err_base | viol;
        err_pulse_d = |(viol & ~err_base);
        code_d      = err_clear ? 4'd0 : code_q;
        if ((err_clear || err_vec_q == '0) && viol != '0) code_d = lowest_bit(viol);
    end

    // NOTE: queue storage is not reset; pointers and counts alone define which entries are live.
    always_ff @(posedge clk) begin
        if (aw_push_ok) begin
            awq_id[awq_wr_q]  <= awid;
            awq_len[awq_wr_q] <= awlen;
        end
        if (b_push_ok) bq_id[bq_wr_q] <= awq_id[awq_rd_q];
        if (ar_push_ok) begin
            arq_id[arq_wr_q]  <= arid;
            arq_len[arq_wr_q] <= arlen;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q     <= '0;
            aw_pl_q     <= '0;
            w_pl_q      <= '0;
            ar_pl_q     <= '0;
            b_pl_q      <= '0;
            r_pl_q      <= '0;
            awq_wr_q    <= '0;
            awq_rd_q    <= '0;
            awq_cnt_q   <= '0;
            bq_wr_q     <= '0;
            bq_rd_q     <= '0;
            bq_cnt_q    <= '0;
            arq_wr_q    <= '0;
            arq_rd_q    <= '0;
            arq_cnt_q   <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            for (int i = 0; i < 5; i++) to_cnt_q[i] <= '0;
            err_vec_q   <= '0;
            err_pulse_q <= 1'b0;
            code_q      <= '0;
        end else begin
            stall_q     <= vld & ~rdy;
            aw_pl_q     <= aw_pl;
            w_pl_q      <= w_pl;
            ar_pl_q     <= ar_pl;
            b_pl_q      <= b_pl;
            r_pl_q      <= r_pl;
            if (aw_push_ok) awq_wr_q <= awq_wr_q + 1'b1;
            if (w_done)     awq_rd_q <= awq_rd_q + 1'b1;
            awq_cnt_q   <= awq_cnt_q + CW'(aw_push_ok) - CW'(w_done);
            if (b_push_ok)  bq_wr_q <= bq_wr_q + 1'b1;
            if (b_pop)      bq_rd_q <= bq_rd_q + 1'b1;
            bq_cnt_q    <= bq_cnt_q + CW'(b_push_ok) - CW'(b_pop);
            if (ar_push_ok) arq_wr_q <= arq_wr_q + 1'b1;
            if (r_done)     arq_rd_q <= arq_rd_q + 1'b1;
            arq_cnt_q   <= arq_cnt_q + CW'(ar_push_ok) - CW'(r_done);
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            for (int i = 0; i < 5; i++) to_cnt_q[i] <= to_cnt_d[i];
            err_vec_q   <= err_vec_d;
            err_pulse_q <= err_pulse_d;
            code_q      <= code_d;
        end
    end

    assign err_vec        = err_vec_q;
    assign err_pulse      = err_pulse_q;
    assign first_err_code = code_q;
    assign err_any        = |err_vec_q;

endmodule

// File: doc/axi_protocol_monitor.md
Name: axi_protocol_monitor

Overview:
Passive, synthesizable AXI4 protocol monitor. It checks all five channels plus transaction bookkeeping, and is parametrised in widths, outstanding depth and timeout. It extends the AR/AW/W stability assertions of the verification interface to B and R stability, burst-length checking, ID ordering, outstanding overflow and hang detection. It taps the bus between the user-request master and the slave in both simulation and FPGA debug builds, and reports sticky error flags.

Parameters:
ID_WIDTH, 4, width of awid/bid/arid/rid
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
LEN_WIDTH, 8, burst length field width
MAX_OUTSTANDING, 4, depth of each tracking queue (AW, B, AR); power of 2, at least 2
TIMEOUT_CYCLES, 256, cycles a VALID may wait for READY before flagging a hang

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
awid/awaddr/awlen/awsize/awburst/awvalid/awready  input  ID/ADDR/LEN/3/2/1/1  AW channel tap
wdata/wstrb/wlast/wvalid/wready  input  DATA/DATA/8/1/1/1  W channel tap
bid/bresp/bvalid/bready  input  ID/2/1/1  B channel tap
arid/araddr/arlen/arsize/arburst/arvalid/arready  input  ID/ADDR/LEN/3/2/1/1  AR channel tap
rid/rdata/rresp/rlast/rvalid/rready  input  ID/DATA/2/1/1/1  R channel tap
err_clear  input  1  synchronous clear of sticky error state
err_vec  output  12  sticky error flags, bit map below
err_pulse  output  1  one-cycle pulse, high in the cycle err_vec gains any new bit
first_err_code  output  4  index of the first error bit ever set since reset/clear
err_any  output  1  OR of err_vec

Behaviour:
- Reset: applied at posedge clk when rst_n=0. All outputs go to 0. All queues are flushed and all beat/timeout counters and previous-cycle registers are zeroed. Reset mid-burst discards tracking state with no error raised.
- Latency: a violation sampled at posedge N is visible on err_vec/err_pulse after posedge N+1 (one register stage).
- Stability, bits 0-4 (AW, W, AR, B, R): if the previous cycle had xVALID=1 and xREADY=0, then in the current cycle xVALID must be 1 and the payload must be unchanged. Payloads:
  - AW/AR: id, addr, len, size, burst
  - W: data, strb, last
  - B: id, resp
  - R: id, data, resp, last
- Handshake: xVALID and xREADY both 1 at posedge.
- AW queue: holds {awid, awlen}, pushed on AW handshake. W beat counter wcnt (LEN_WIDTH+1 bits).
  - On each W handshake, check wlast == (wcnt == head.len). A mismatch sets bit 5. On wlast, or when wcnt reaches head.len, pop the head, push its id into the B queue, and clear wcnt; otherwise increment wcnt.
  - A W handshake with the AW queue empty sets bit 7. W-before-AW is unsupported by our master; the beat is ignored.
- B handshake: the B queue must be non-empty and bid must equal the head, otherwise set bit 8. Pop the head if non-empty.
- AR queue: holds {arid, arlen}. R beat counter rcnt behaves like wcnt.
  - rlast mismatch sets bit 6.
  - An R handshake with the queue empty, or rid != head id, sets bit 9. Ordering is in-order only.
- Overflow: a push into a full queue with no same-cycle pop sets bit 10, and the push is dropped. Simultaneous push and pop when full is legal.
- Timeout: each of the 5 channels has a counter. It increments while xVALID=1 and xREADY=0, and clears on handshake or xVALID=0. Reaching TIMEOUT_CYCLES sets bit 11. The counter saturates, so a stall flags only once.
- Bit map: 0 AW_STABLE, 1 W_STABLE, 2 AR_STABLE, 3 B_STABLE, 4 R_STABLE, 5 WLAST, 6 RLAST, 7 W_NO_AW, 8 B_UNEXP, 9 R_UNEXP, 10 OVF, 11 TIMEOUT.
- Sticky state: bits stay set until err_clear or reset.
  - If several bits are newly set while err_any=0, first_err_code takes the lowest index.
  - err_clear zeroes err_vec and first_err_code. If a violation occurs in the same cycle as err_clear, the violation wins: its bit is set and first_err_code is loaded.
- X values on inputs are treated per the simulator. Synthesis tracking logic uses no X checks.

Test Plan:
1. Clean traffic: AW id=3 len=3, four W beats with wlast on beat 4, B id=3; AR id=1 len=7, eight R beats, rlast on beat 8 -> err_vec=0, err_pulse never asserted.
2. Stability: awvalid=1, awready=0, awaddr changes 0x100->0x104 on the next cycle -> err_vec=0x001 one cycle later, err_pulse for one cycle, first_err_code=0.
3. Burst length: AW len=1, wlast asserted on beat 1 -> bit 5 set. Then AR len=2 with rlast missing on beat 3 -> bit 6 also set, first_err_code stays 5.
4. Ordering/unexpected: AR id=2 followed by an R beat with rid=5 -> bit 9. bvalid with an empty B queue -> bit 8.
5. Overflow and timeout: 5 AR handshakes with no R (MAX_OUTSTANDING=4) -> bit 10. arvalid held with arready=0 for 256 cycles -> bit 11 set exactly once.
6. Clear/reset: err_clear pulsed in the same cycle as a W stability violation -> err_vec=0x002 and first_err_code=1. rst_n=0 mid-burst, then clean traffic -> all zero, no spurious errors.
